fetch_unit: RTL

- Program-counter and fetch-control stage that sits directly upstream of the instruction ROM and drives its address.
- It consumes the ROM's registered read data, which is returned one cycle after the address.
- It presents {instruction, PC} to decode through a valid/ready handshake.
- It handles decode back-pressure and branch/jump redirects from execute without losing or duplicating instructions.

---
 rtl/fetch_unit.sv | 82 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Program-counter / fetch-control stage feeding a registered-output
// instruction ROM and presenting {instruction, PC} to decode via valid/ready.
module fetch_unit #(
  parameter int unsigned           PCWIDTH      = 32,
  parameter int unsigned           AWIDTH       = 12,
  parameter int unsigned           DWIDTH       = 32,
  parameter logic [PCWIDTH-1:0]    RESET_VECTOR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [AWIDTH-1:0]   rom_addr,
  input  logic [DWIDTH-1:0]   rom_qout,
  input  logic                redirect_valid,
  input  logic [PCWIDTH-1:0]  redirect_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [DWIDTH-1:0]   dec_inst,
  output logic [PCWIDTH-1:0]  dec_pc,
  output logic                dec_misalign
);

  logic [PCWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PCWIDTH-1:0] out_pc_q,   out_pc_d;
  logic               out_valid_q, out_valid_d;
  logic               out_mis_q,   out_mis_d;

  logic               advance;
  logic [PCWIDTH-1:0] redirect_aligned;

  assign advance          = !out_valid_q || dec_ready;
  assign redirect_aligned = {redirect_pc[PCWIDTH-1:2], 2'b00};

  assign dec_valid    = out_valid_q && !redirect_valid;
  assign dec_pc       = out_pc_q;
  assign dec_misalign = out_mis_q;
  assign dec_inst     = rom_qout;

  // ROM address select: redirect target, next sequential PC, or re-read on stall
  always_comb begin
    rom_addr = out_pc_q[AWIDTH+1:2];
    if (redirect_valid) begin
      rom_addr = redirect_pc[AWIDTH+1:2];
    end else if (advance) begin
      rom_addr = fetch_pc_q[AWIDTH+1:2];
    end
  end

  // Next-state for PC / output-slot registers; stall holds everything
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    out_mis_d   = out_mis_q;
    if (redirect_valid) begin
      out_pc_d    = redirect_pc;
      out_mis_d   = |redirect_pc[1:0];
      out_valid_d = 1'b1;
      fetch_pc_d  = redirect_aligned + PCWIDTH'(4);
    end else if (advance) begin
      out_pc_d    = fetch_pc_q;
      out_mis_d   = 1'b0;
      out_valid_d = 1'b1;
      fetch_pc_d  = fetch_pc_q + PCWIDTH'(4);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_VECTOR;
      out_pc_q    <= RESET_VECTOR;
      out_valid_q <= 1'b0;
      out_mis_q   <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      out_mis_q   <= out_mis_d;
    end
  end

endmodule
